// File: rtl/evt_pulse_stretch_pkg.sv
// Shared definitions for the event pulse stretcher: FSM encodings and the
// board-level default for the human-visible pulse length.
package evt_pulse_stretch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ON   = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // ~10 ms at the board clock; the debounce window uses the same figure.
    localparam int unsigned BOARD_VISIBLE_CYCLES = 1048576;

    // Width needed to count 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evt_pulse_stretch_if.sv
// Event-in / indicator-out bundle between CPU status strobes and the LED driver.
interface evt_pulse_stretch_if #(
    parameter int PEND_W = 4
);
    logic              pulse_in;
    logic              ovf_clr;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              ovf;

    modport master (
        output pulse_in, ovf_clr,
        input  led, busy, pending, ovf
    );

    modport slave (
        input  pulse_in, ovf_clr,
        output led, busy, pending, ovf
    );
endinterface

// File: rtl/evt_pend_cnt.sv
// Saturating up/down counter for queued events; flags an increment that
// could not be stored because the counter was already full.
module evt_pend_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_drop
);

    localparam logic [W-1:0] CNT_MAX = '1;

    function automatic logic [W-1:0] sat_step(input logic [W-1:0] c,
                                              input logic up,
                                              input logic dn);
        logic [W-1:0] r;
        r = c;
        if (up && !dn && (c != CNT_MAX))
            r = c + W'(1);
        else if (dn && !up && (c != '0))
            r = c - W'(1);
        return r;
    endfunction

    assign sat_drop = inc & ~dec & (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= sat_step(cnt, inc, dec);
    end

endmodule

// File: rtl/evt_pulse_stretch.sv
// Stretches single-cycle event strobes into fixed-length LED pulses separated
// by a forced dark gap, queueing events that arrive while a pulse is showing.
module evt_pulse_stretch
    import evt_pulse_stretch_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = BOARD_VISIBLE_CYCLES,
    parameter int unsigned GAP_CYCLES = BOARD_VISIBLE_CYCLES,
    parameter int          CNT_W      = 21,
    parameter int          PEND_W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    evt_pulse_stretch_if.slave bus
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              led_q;
    logic              ovf_q;
    logic [PEND_W-1:0] pend;
    logic              pend_nz;
    logic              sat_drop;
    logic              on_last;
    logic              gap_last;
    logic              take;
    logic              acc;
    logic              dec;

    assign pend_nz  = (pend != '0);
    assign on_last  = (state == ST_ON)  && (cnt == ON_LAST);
    assign gap_last = (state == ST_GAP) && (cnt == GAP_LAST);

    // A new pulse may start from IDLE or directly off the final gap cycle,
    // which is what keeps back-to-back events free of an idle bubble.
    assign take = ((state == ST_IDLE) || gap_last) && (pend_nz || bus.pulse_in);

    // The queue is served first; a live pulse only bypasses it when empty.
    assign acc = bus.pulse_in & ~(take & ~pend_nz);
    assign dec = take & pend_nz;

    evt_pend_cnt #(
        .W (PEND_W)
    ) u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (acc),
        .dec      (dec),
        .cnt      (pend),
        .sat_drop (sat_drop)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (take) begin
            state_nxt = ST_ON;
            cnt_nxt   = '0;
        end else if (on_last) begin
            state_nxt = ST_GAP;
            cnt_nxt   = '0;
        end else if (gap_last) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if ((state == ST_ON) || (state == ST_GAP)) begin
            cnt_nxt   = cnt + CNT_W'(1);
        end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            led_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            led_q <= (state_nxt == ST_ON);
        end
    end

    // A drop in the same cycle as a clear must stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (sat_drop)
            ovf_q <= 1'b1;
        else if (bus.ovf_clr)
            ovf_q <= 1'b0;
    end

    assign bus.led     = led_q;
    assign bus.ovf     = ovf_q;
    assign bus.pending = pend;
    assign bus.busy    = (state != ST_IDLE) | pend_nz;

endmodule

// File: doc/evt_pulse_stretch.md
Name: evt_pulse_stretch

Overview:
Inverse of the button-side conditioning path. It takes single-cycle internal event pulses (instruction step, write strobe, halt, and similar) and turns each one into a human-visible LED/indicator pulse of fixed length, followed by a mandatory dark gap. Pulses that arrive while a pulse is being displayed are queued in a saturating pending counter. A sticky overflow flag reports events that were dropped. The block sits between CPU status strobes and the board LED/display drivers.

Parameters:
ON_CYCLES, 1048576, visible-high duration in clk cycles; must be >= 1.
GAP_CYCLES, 1048576, forced-low gap after each high phase; must be >= 1.
CNT_W, 21, width of the duration counter; must hold max(ON_CYCLES, GAP_CYCLES) - 1.
PEND_W, 4, pending-counter width; max queued count is PMAX = 2^PEND_W - 1.

Ports:
clk      in   1       system clock
rst_n    in   1       asynchronous active-low reset
pulse_in in   1       event strobe, sampled every rising edge; each high cycle counts as one event
ovf_clr  in   1       clears ovf
led      out  1       stretched output, registered
busy     out  1       (state != IDLE) | (pending != 0)
pending  out  PEND_W  queued events not yet displayed
ovf      out  1       sticky: at least one event was dropped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, led=0, cnt=0, pending=0, ovf=0. Asserting reset mid-operation drops led immediately and discards the queue.
- States:
  - IDLE: led=0.
  - ON: led=1, cnt counts 0..ON_CYCLES-1.
  - GAP: led=0, cnt counts 0..GAP_CYCLES-1.
- take = (state==IDLE | (state==GAP & cnt==GAP_CYCLES-1)) & (pending!=0 | pulse_in).
- Transitions:
  - take -> ON, cnt=0.
  - ON with cnt==ON_CYCLES-1 -> GAP, cnt=0.
  - GAP last cycle with !take -> IDLE.
  - Otherwise hold state, cnt+1.
- When take is true, the queue is served first: if pending!=0, the dispatched event comes from the queue, otherwise it is the current pulse_in.
- Pending update:
  - acc = pulse_in & !(take & pending==0).
  - dec = take & pending!=0.
  - pending_next = pending + acc - dec.
  - If acc & !dec & pending==PMAX: pending holds at PMAX, the event is dropped, and ovf<=1.
- Latency: a pulse sampled at edge k while IDLE and queue empty drives led=1 from cycle k+1 for exactly ON_CYCLES cycles.
- Back-to-back events: period is exactly ON_CYCLES+GAP_CYCLES with no IDLE bubble.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Counters use no wrap-around: pending saturates at PMAX and at 0; cnt always resets on each state change.
- All outputs are registered except busy, which is a combinational OR of registered values.

Decomposition:
- Shared package/header: state encodings ST_IDLE=2'd0, ST_ON=2'd1, ST_GAP=2'd2, plus a board default constant for the visible duration (the ~10 ms figure at board clk, shared with the debounce window).
- One natural sub-module, evt_pend_cnt: a saturating up/down counter with inputs inc, dec and outputs cnt, sat_drop.
- The FSM and the duration counter stay in the top.

Test Plan (ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2, PMAX=3):
1. Single pulse at cycle 10 -> led=1 on cycles 11-14, 0 on 15-17; state IDLE and busy=0 from cycle 18.
2. Pulses at cycles 10, 11, 12 -> pending=1 at 12, 2 at 13; led high 11-14, 18-21, 25-28; pending 1 at 18, 0 at 25; ovf=0.
3. Pulses at cycles 10-14 -> pending reaches 3 at 14; the 5th pulse is dropped and ovf=1 at 15; exactly 4 led pulses total.
4. While ovf=1, ovf_clr=1 in the same cycle as another drop -> ovf stays 1; ovf_clr alone next cycle -> ovf=0.
5. rst_n low at cycle 12 (mid-ON, pending=2) -> led=0, pending=0 immediately; after release, a pulse at cycle 20 -> led high 21-24.
6. Pulse exactly on the GAP last cycle (cycle 17 of scenario 1), queue empty -> led=1 at 18 with no IDLE cycle; pending stays 0.
